// File: rtl/ls_debounce_pkg.sv
// rtl/ls_debounce_pkg.sv - shared constants for the limit-switch debounce filter
package ls_debounce_pkg;

    localparam int          LSD_CNT_W         = 16;
    localparam logic [15:0] LSD_DEFAULT_LIMIT = 16'd5000;

    localparam logic [1:0] LSD_ADDR_OUT   = 2'd0;
    localparam logic [1:0] LSD_ADDR_LIMIT = 2'd1;
    localparam logic [1:0] LSD_ADDR_RAW   = 2'd2;
    localparam logic [1:0] LSD_ADDR_RSVD  = 2'd3;

endpackage

// File: rtl/ls_debounce_chan.sv
// rtl/ls_debounce_chan.sv - one channel: two-flop synchroniser plus stability counter
module ls_debounce_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic [CNT_W-1:0] limit,
    input  logic             clr,
    output logic             sync_level,
    output logic             filt,
    output logic             change
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    assign sync_level = s2;

    // A limit write (clr) outranks everything, including a coincident terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            filt   <= 1'b0;
            change <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            change <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (limit == '0) begin
                cnt    <= '0;
                filt   <= s2;
                change <= (s2 != filt);
            end else if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == limit - CNT_W'(1)) begin
                cnt    <= '0;
                filt   <= s2;
                change <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ls_debounce_filter.sv
// rtl/ls_debounce_filter.sv - six-channel limit-switch debounce with Avalon-MM control
module ls_debounce_filter
    import ls_debounce_pkg::*;
#(
    parameter int               WIDTH         = 6,
    parameter int               CNT_W         = LSD_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(LSD_DEFAULT_LIMIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [CNT_W-1:0] writedata,
    output logic [CNT_W-1:0] readdata,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] change
);

    logic [CNT_W-1:0] limit;
    logic [WIDTH-1:0] s2_vec;
    logic             limit_wr;

    assign limit_wr = chipselect && !write_n && (address == LSD_ADDR_LIMIT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        ls_debounce_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_in[i]),
            .limit      (limit),
            .clr        (limit_wr),
            .sync_level (s2_vec[i]),
            .filt       (out_port[i]),
            .change     (change[i])
        );
    end

    // readdata is reloaded every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            limit    <= DEFAULT_LIMIT;
            readdata <= '0;
        end else begin
            if (limit_wr) begin
                limit <= writedata;
            end
            case (address)
                LSD_ADDR_OUT:   readdata <= {{(CNT_W-WIDTH){1'b0}}, out_port};
                LSD_ADDR_LIMIT: readdata <= limit;
                LSD_ADDR_RAW:   readdata <= {{(CNT_W-WIDTH){1'b0}}, s2_vec};
                default:        readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_debounce_filter.sv
// tb/tb_ls_debounce_filter.sv - directed self-checking bench for ls_debounce_filter
module tb_ls_debounce_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  raw_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [5:0]  out_port;
    logic [5:0]  change;

    int checks = 0;
    int errors = 0;

    ls_debounce_filter dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .change     (change)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        raw_in     = 6'h3F;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0;

        // Reset behaviour with all pins high
        tick();
        tick();
        check("reset_out_port", {10'h0, out_port}, 16'h0000);
        check("reset_readdata", readdata, 16'h0000);
        check("reset_change", {10'h0, change}, 16'h0000);
        reset   = 1'b0;
        raw_in  = 6'h00;
        address = 2'd1;
        tick();
        check("reset_limit_read", readdata, 16'd5000);

        // Clean step on channel 0, limit 4
        write_reg(2'd1, 16'd4);
        raw_in[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("step_hold", {15'h0, out_port[0]}, 16'h0);
        end
        tick();
        check("step_rise", {15'h0, out_port[0]}, 16'h1);
        check("step_change", {10'h0, change}, 16'h0001);
        tick();
        check("step_change_end", {10'h0, change}, 16'h0000);
        check("step_out_held", {10'h0, out_port}, 16'h0001);

        // Bounce rejection on channel 2
        raw_in[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bounce_pulse", {15'h0, out_port[2]}, 16'h0);
        end
        raw_in[2] = 1'b0;
        tick();
        check("bounce_gap", {15'h0, out_port[2]}, 16'h0);
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("bounce_hold", {15'h0, out_port[2]}, 16'h0);
            check("bounce_no_change", {10'h0, change}, 16'h0);
        end
        tick();
        check("bounce_rise", {10'h0, out_port}, 16'h0005);
        check("bounce_change", {10'h0, change}, 16'h0004);

        // Readback with out_port=05 and s2=07
        raw_in = 6'h07;
        tick();
        tick();
        address = 2'd0;
        tick();
        check("read_addr0", readdata, 16'h0005);
        address = 2'd2;
        tick();
        check("read_addr2", readdata, 16'h0007);
        address = 2'd3;
        tick();
        check("read_addr3", readdata, 16'h0000);

        // Limit write collides with terminal count on channel 3
        raw_in = 6'h00;
        do_reset();
        write_reg(2'd1, 16'd4);
        raw_in[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        check("coll_before", {10'h0, out_port}, 16'h0000);
        write_reg(2'd1, 16'd10);
        check("coll_no_update", {10'h0, out_port}, 16'h0000);
        check("coll_no_change", {10'h0, change}, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("coll_hold", {10'h0, out_port}, 16'h0000);
        end
        tick();
        check("coll_rise", {10'h0, out_port}, 16'h0008);
        check("coll_change", {10'h0, change}, 16'h0008);
        address = 2'd1;
        tick();
        check("coll_limit_read", readdata, 16'd10);

        // Bypass with limit 0
        raw_in = 6'h00;
        do_reset();
        write_reg(2'd1, 16'd0);
        raw_in = 6'h2A;
        tick();
        tick();
        check("bypass_wait", {10'h0, out_port}, 16'h0000);
        tick();
        check("bypass_out", {10'h0, out_port}, 16'h002A);
        check("bypass_change", {10'h0, change}, 16'h002A);
        tick();
        check("bypass_change_end", {10'h0, change}, 16'h0000);
        check("bypass_out_held", {10'h0, out_port}, 16'h002A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ls_debounce_filter.md
# ls_debounce_filter

Six-channel limit-switch input conditioner that sits directly upstream of the limit-switch interrupt PIO. Each raw pin is synchronised into the `clk` domain and passed through a programmable-length stability filter. The filtered vector drives the PIO `in_port`, so contact bounce cannot cause spurious edge captures or interrupts. A small Avalon-MM slave sets the filter length and exposes the raw and filtered values for diagnostics.

## Interface
- `WIDTH`, 6: number of input channels.
- `CNT_W`, 16: filter counter width, in bits.
- `DEFAULT_LIMIT`, 16'd5000: filter length loaded at reset, in `clk` cycles.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: reset is synchronous and active-high.
- `raw_in` in WIDTH: asynchronous switch pins.
- `address` in 2: Avalon-MM register select.
- `chipselect` in 1: Avalon-MM slave select.
- `write_n` in 1: Avalon-MM write strobe, active-low.
- `writedata` in CNT_W: Avalon-MM write data.
- `readdata` out CNT_W: registered read data.
- `out_port` out WIDTH: filtered levels, connected to the PIO `in_port`.
- `change` out WIDTH: one-cycle pulse per channel when `out_port` bit toggles.

## Operation
- Synchroniser:
  - Two flops per channel: `raw_in` → `s1` → `s2`.
  - `s2` is the sampled level used by the filter.
- Per-channel counter `cnt` (CNT_W bits), two states:
  - STABLE: `s2 == out_port[i]`. `cnt <= 0`.
  - PENDING: `s2 != out_port[i]`. `cnt <= cnt + 1`.
  - When `cnt == limit - 1` while PENDING: `out_port[i] <= s2`, `cnt <= 0`, `change[i] <= 1`.
  - Any return of `s2` to `out_port[i]` before the terminal count clears `cnt`. There is no partial credit.
- `limit == 0` is bypass: `out_port <= s2` every cycle. `change` pulses on every difference.
- Counter saturates by construction, because the terminal compare precedes wrap. No wrap-around is possible.
- Register map, write when `chipselect && !write_n`:
  - Address 0: R, filtered `out_port`, zero-extended.
  - Address 1: R/W, `limit`. A write clears all `cnt` to 0.
  - Address 2: R, `s2` raw synchronised vector, zero-extended.
  - Address 3: R, returns 0. Writes are ignored.
- Simultaneous limit write and terminal count on the same cycle: the write wins. Counters clear, `out_port` is not updated, and `change` stays 0.
- Reset values:
  - `s1`, `s2`, `cnt`, `out_port`, `change`, `readdata`: 0.
  - `limit`: `DEFAULT_LIMIT`.
- Reset asserted mid-count: everything returns to reset values on the next edge. There is no pending update.

## Timing
- Read latency is 1 cycle. `readdata` is registered every cycle from the `address` mux, independent of `chipselect`.
- A limit write takes effect on the cycle after the write edge.
- Pin-to-`out_port` latency for a clean step is 2 (sync) + `limit` cycles. With `limit == 0` it is 2 cycles plus the register stage, i.e. 3 cycles.
- `change[i]` is asserted in the same cycle `out_port[i]` first shows its new value, for exactly 1 cycle.
- Downstream PIO edge detection therefore sees at most one edge per `limit` cycles per channel.

## Structure
- Package `ls_debounce_pkg`:
  - Register address constants `LSD_ADDR_OUT`, `LSD_ADDR_LIMIT`, `LSD_ADDR_RAW`.
  - Default `CNT_W` and `DEFAULT_LIMIT`.
- Sub-module `ls_debounce_chan`, instantiated WIDTH times by a generate loop:
  - Contains the sync pair, the counter, the terminal compare and the output flop.
  - Takes a shared `limit` and a `clr` pulse.
- The top level holds the limit register, the read mux and `readdata`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `raw_in = 6'h3F`.
  - During reset: `out_port = 0`, `readdata = 0`.
  - A read of address 1 returns 5000.
- **Clean step:** write limit = 4, then drive `raw_in[0]` 0→1 and hold.
  - `out_port[0]` rises exactly 6 cycles after the pin change.
  - `change[0]` is high for 1 cycle.
- **Bounce rejection:** limit = 4. Toggle `raw_in[2]` high for 3 cycles, low for 1 cycle, then high and held.
  - No output during the first pulse.
  - `out_port[2]` rises 6 cycles after the final rise.
- **Bypass:** write limit = 0 and drive `raw_in = 6'h2A`.
  - `out_port = 6'h2A` 3 cycles later.
  - `change = 6'h2A` for 1 cycle.
- **Write collision:** limit = 4. Issue a limit write of 10 on the exact cycle `cnt` reaches 3.
  - No update on that cycle.
  - `out_port` changes 10 cycles later.
- **Readback:** with `out_port = 6'h05` and `s2 = 6'h07`:
  - A read of address 0 returns 5.
  - A read of address 2 returns 7.
  - A read of address 3 returns 0.
  - Each `readdata` is valid 1 cycle after the address is presented.
